// File: rtl/ahb_mslv_ram_resp.sv
// AHB-Lite responder backed by a word-organised RAM, with programmable OKAY
// wait states and two-cycle ERROR responses on misaligned or oversize transfers.
module ahb_mslv_ram_resp #(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ahb_mslv_hsel,
  input  logic [31:0] ahb_mslv_haddr,
  input  logic [1:0]  ahb_mslv_htrans,
  input  logic        ahb_mslv_hwrite,
  input  logic [2:0]  ahb_mslv_hsize,
  input  logic [2:0]  ahb_mslv_hburst,
  input  logic [3:0]  ahb_mslv_hprot,
  input  logic        ahb_mslv_hlock,
  input  logic [31:0] ahb_mslv_hwdata,
  input  logic        ahb_mslv_hready,
  output logic [31:0] ahb_mslv_hrdata,
  output logic        ahb_mslv_hreadyout,
  output logic [1:0]  ahb_mslv_hresp
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAITS, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [MEM_AW-1:0]   addr_q;
  logic                write_q;
  logic [3:0]          be_q;
  logic [31:0]         mem [0:(1<<MEM_AW)-1];

  logic                ready_st, accept, acc_err, commit, rd_go;
  logic [3:0]          acc_be;
  logic [MEM_AW-1:0]   acc_word, rd_word;
  logic [31:0]         rd_data;
  logic                unused;

  assign unused = ^{ahb_mslv_hburst, ahb_mslv_hprot, ahb_mslv_hlock,
                    ahb_mslv_htrans[0], ahb_mslv_haddr[31:MEM_AW+2]};

  assign ready_st = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept   = ready_st && ahb_mslv_hsel && ahb_mslv_hready && ahb_mslv_htrans[1];
  assign acc_word = ahb_mslv_haddr[MEM_AW+1:2];
  assign commit   = (state == ST_DATA) && write_q;

  always_comb begin
    acc_be  = '0;
    acc_err = 1'b0;
    case (ahb_mslv_hsize)
      3'd0: acc_be = 4'b0001 << ahb_mslv_haddr[1:0];
      3'd1: begin
        acc_be  = ahb_mslv_haddr[1] ? 4'b1100 : 4'b0011;
        acc_err = ahb_mslv_haddr[0];
      end
      3'd2: begin
        acc_be  = '1;
        acc_err = |ahb_mslv_haddr[1:0];
      end
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept) begin
          state_nxt = ST_IDLE;
        end else if (acc_err) begin
          state_nxt = ST_ERR1;
        end else if (WAIT > 0) begin
          state_nxt = ST_WAITS;
          cnt_nxt   = WAIT_M1;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      ST_WAITS: begin
        if (cnt == 4'd0) state_nxt = ST_DATA;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= acc_word;
        write_q <= ahb_mslv_hwrite;
        be_q    <= acc_be;
      end
    end
  end

  // A read enters DATA either straight from an address phase (no wait states)
  // or from the last WAITS cycle using the registered address.
  assign rd_go   = (WAIT == 0) ? (accept && !acc_err && !ahb_mslv_hwrite)
                               : ((state == ST_WAITS) && (cnt == 4'd0) && !write_q);
  assign rd_word = (state == ST_WAITS) ? addr_q : acc_word;

  // Lanes written on this same edge are forwarded so the read sees the new data.
  always_comb begin
    rd_data = mem[rd_word];
    if (commit && (addr_q == rd_word)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) rd_data[8*i +: 8] = ahb_mslv_hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ahb_mslv_hrdata <= '0;
    else if (rd_go) ahb_mslv_hrdata <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[addr_q][8*i +: 8] <= ahb_mslv_hwdata[8*i +: 8];
      end
    end
  end

  assign ahb_mslv_hreadyout = !((state == ST_WAITS) || (state == ST_ERR1));
  assign ahb_mslv_hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

endmodule
